// File: rtl/ssd_scan_ctl_pkg.sv
// Shared constants, payload type and helpers for the seven-segment scan controller.
package ssd_scan_ctl_pkg;

    localparam int unsigned SSD_DIGITS = 4;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned VAL_W      = SSD_DIGITS * NIB_W;

    localparam logic [SSD_DIGITS-1:0] SSD_OFF = 4'b1111;

    // Registered drive toward the display and the segment decoder.
    typedef struct packed {
        logic [NIB_W-1:0]      d;
        logic [SSD_DIGITS-1:0] en_n;
        logic                  blank;
    } ssd_drive_t;

    // Digit index to active-low one-hot enable.
    function automatic logic [SSD_DIGITS-1:0] ssd_digit_en(input logic [IDX_W-1:0] idx);
        ssd_digit_en = ~(SSD_DIGITS'(1) << idx);
    endfunction

    // Nibble of a packed value at a digit index.
    function automatic logic [NIB_W-1:0] ssd_nibble(input logic [VAL_W-1:0] val,
                                                    input logic [IDX_W-1:0] idx);
        case (idx)
            2'd0:    ssd_nibble = val[3:0];
            2'd1:    ssd_nibble = val[7:4];
            2'd2:    ssd_nibble = val[11:8];
            default: ssd_nibble = val[15:12];
        endcase
    endfunction

    // A digit is a leading zero when it and every digit above it are zero; digit 0 never is.
    function automatic logic ssd_lz(input logic [VAL_W-1:0] val,
                                    input logic [IDX_W-1:0] idx);
        logic zero_above;
        zero_above = 1'b1;
        ssd_lz     = 1'b0;
        for (int k = SSD_DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above & (val[k*NIB_W +: NIB_W] == 4'h0);
            if (k == int'(idx)) begin
                ssd_lz = zero_above;
            end
        end
    endfunction

endpackage

// File: rtl/ssd_prescaler.sv
// Free-running prescaler: tick_o is high for one clock every 2^DIV_BITS clocks,
// while the internal count sits at all ones.
//   clk, rst_n : clock, async active-low reset
//   tick_o     : registered terminal-count strobe
module ssd_prescaler #(
    parameter int unsigned DIV_BITS = 17
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    logic [DIV_BITS-1:0] cnt_q, cnt_d;
    logic                tick_q, tick_d;

    // Tick is registered from the next count so it lines up with cnt_q == all ones.
    always_comb begin
        cnt_d  = cnt_q + DIV_BITS'(1);
        tick_d = (cnt_d == {DIV_BITS{1'b1}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/ssd_scan_ctl.sv
// Time-multiplexed 4-digit seven-segment scan with double-buffered, tear-free loads
// and optional leading-zero blanking.
//   clk, rst_n : clock, async active-low reset
//   load       : capture value into the shadow register
//   value      : packed digits, [3:0] is the rightmost digit
//   blank_lz   : suppress leading zeros
//   d          : nibble of the scanned digit (to the segment decoder)
//   ssd_ctl    : active-low one-hot digit enable
//   blank      : current digit is suppressed
//   frame_done : one-clock pulse after digit 3's period
//   pending    : a loaded value waits for the frame boundary
module ssd_scan_ctl
    import ssd_scan_ctl_pkg::*;
#(
    parameter int unsigned DIV_BITS = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [VAL_W-1:0]      value,
    input  logic                  blank_lz,
    output logic [NIB_W-1:0]      d,
    output logic [SSD_DIGITS-1:0] ssd_ctl,
    output logic                  blank,
    output logic                  frame_done,
    output logic                  pending
);

    logic             tick;
    logic             wrap_c;
    logic             lz_c;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [VAL_W-1:0] shadow_q, shadow_d;
    logic [VAL_W-1:0] active_q, active_d;
    logic             pending_q, pending_d;
    logic             frame_done_q, frame_done_d;
    ssd_drive_t       drv_q, drv_d;

    localparam ssd_drive_t DRV_RST = '{d: 4'h0, en_n: 4'b1110, blank: 1'b0};

    ssd_prescaler #(
        .DIV_BITS (DIV_BITS)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (tick)
    );

    assign wrap_c = tick && (idx_q == IDX_W'(SSD_DIGITS - 1));

    // Next-state: index, double buffer, and drive computed from the next index/value.
    always_comb begin
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        pending_d    = pending_q;
        frame_done_d = wrap_c;
        drv_d        = drv_q;
        lz_c         = 1'b0;

        if (tick) begin
            idx_d = idx_q + IDX_W'(1);
        end

        // Active takes the pre-load shadow on a coincident wrap; the new load stays pending.
        if (wrap_c) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (load) begin
            shadow_d  = value;
            pending_d = 1'b1;
        end

        if (tick) begin
            lz_c        = blank_lz && ssd_lz(active_d, idx_d);
            drv_d.d     = ssd_nibble(active_d, idx_d);
            drv_d.blank = lz_c;
            drv_d.en_n  = lz_c ? SSD_OFF : ssd_digit_en(idx_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            shadow_q     <= '0;
            active_q     <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            drv_q        <= DRV_RST;
        end else begin
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            drv_q        <= drv_d;
        end
    end

    assign d          = drv_q.d;
    assign ssd_ctl    = drv_q.en_n;
    assign blank      = drv_q.blank;
    assign frame_done = frame_done_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_ssd_scan_ctl.sv
// Directed bench for ssd_scan_ctl with a 4-clock digit period (16-clock frame).
module tb_ssd_scan_ctl;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic        blank_lz;
    logic [3:0]  d;
    logic [3:0]  ssd_ctl;
    logic        blank;
    logic        frame_done;
    logic        pending;

    int tests;
    int errors;

    ssd_scan_ctl #(
        .DIV_BITS (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .blank_lz   (blank_lz),
        .d          (d),
        .ssd_ctl    (ssd_ctl),
        .blank      (blank),
        .frame_done (frame_done),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reset, then release at a falling edge; the next rising edge is edge 1.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        load     = 1'b0;
        value    = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        load  = 1'b0;
        #1;
        tests++;
        if (ssd_ctl !== 4'b1110 || d !== 4'h0 || pending !== 1'b0 || frame_done !== 1'b0 || blank !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ssd_ctl=%b d=%h pending=%b fd=%b blank=%b, expected 1110 0 0 0 0",
                     ssd_ctl, d, pending, frame_done, blank);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(3);
        tests++;
        if (ssd_ctl !== 4'b1110) begin
            errors++;
            $display("FAIL scan_hold: ssd_ctl=%b expected 1110", ssd_ctl);
        end
        step(1);
        tests++;
        if (ssd_ctl !== 4'b1101) begin errors++; $display("FAIL scan_d1: ssd_ctl=%b expected 1101", ssd_ctl); end
        step(4);
        tests++;
        if (ssd_ctl !== 4'b1011) begin errors++; $display("FAIL scan_d2: ssd_ctl=%b expected 1011", ssd_ctl); end
        step(4);
        tests++;
        if (ssd_ctl !== 4'b0111) begin errors++; $display("FAIL scan_d3: ssd_ctl=%b expected 0111", ssd_ctl); end
        step(4);
        tests++;
        if (ssd_ctl !== 4'b1110) begin errors++; $display("FAIL scan_wrap: ssd_ctl=%b expected 1110", ssd_ctl); end
    endtask

    task automatic test_load();
        do_reset();
        step(6);
        load  = 1'b1;
        value = 16'h1234;
        step(1);
        load = 1'b0;
        tests++;
        if (pending !== 1'b1 || d !== 4'h0 || ssd_ctl !== 4'b1101) begin
            errors++;
            $display("FAIL load_pending: pending=%b d=%h ssd_ctl=%b expected 1 0 1101", pending, d, ssd_ctl);
        end
        step(8);
        tests++;
        if (pending !== 1'b1 || d !== 4'h0 || ssd_ctl !== 4'b0111) begin
            errors++;
            $display("FAIL load_prewrap: pending=%b d=%h ssd_ctl=%b expected 1 0 0111", pending, d, ssd_ctl);
        end
        step(1);
        tests++;
        if (d !== 4'h4 || ssd_ctl !== 4'b1110 || pending !== 1'b0 || frame_done !== 1'b1) begin
            errors++;
            $display("FAIL load_wrap: d=%h ssd_ctl=%b pending=%b fd=%b expected 4 1110 0 1",
                     d, ssd_ctl, pending, frame_done);
        end
        step(1);
        tests++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL load_fd_clear: fd=%b expected 0", frame_done); end
        step(3);
        tests++;
        if (d !== 4'h3 || ssd_ctl !== 4'b1101) begin
            errors++; $display("FAIL load_dig1: d=%h ssd_ctl=%b expected 3 1101", d, ssd_ctl);
        end
        step(4);
        tests++;
        if (d !== 4'h2 || ssd_ctl !== 4'b1011) begin
            errors++; $display("FAIL load_dig2: d=%h ssd_ctl=%b expected 2 1011", d, ssd_ctl);
        end
        step(4);
        tests++;
        if (d !== 4'h1 || ssd_ctl !== 4'b0111) begin
            errors++; $display("FAIL load_dig3: d=%h ssd_ctl=%b expected 1 0111", d, ssd_ctl);
        end
    endtask

    task automatic test_blank();
        do_reset();
        blank_lz = 1'b1;
        load     = 1'b1;
        value    = 16'h0070;
        step(1);
        load = 1'b0;
        step(15);
        tests++;
        if (d !== 4'h0 || ssd_ctl !== 4'b1110 || blank !== 1'b0) begin
            errors++; $display("FAIL lz_dig0: d=%h ssd_ctl=%b blank=%b expected 0 1110 0", d, ssd_ctl, blank);
        end
        step(4);
        tests++;
        if (d !== 4'h7 || ssd_ctl !== 4'b1101 || blank !== 1'b0) begin
            errors++; $display("FAIL lz_dig1: d=%h ssd_ctl=%b blank=%b expected 7 1101 0", d, ssd_ctl, blank);
        end
        step(4);
        tests++;
        if (d !== 4'h0 || ssd_ctl !== 4'b1111 || blank !== 1'b1) begin
            errors++; $display("FAIL lz_dig2: d=%h ssd_ctl=%b blank=%b expected 0 1111 1", d, ssd_ctl, blank);
        end
        step(4);
        tests++;
        if (d !== 4'h0 || ssd_ctl !== 4'b1111 || blank !== 1'b1) begin
            errors++; $display("FAIL lz_dig3: d=%h ssd_ctl=%b blank=%b expected 0 1111 1", d, ssd_ctl, blank);
        end
        load  = 1'b1;
        value = 16'h0000;
        step(1);
        load = 1'b0;
        step(3);
        tests++;
        if (d !== 4'h0 || ssd_ctl !== 4'b1110 || blank !== 1'b0) begin
            errors++; $display("FAIL lz_zero_dig0: d=%h ssd_ctl=%b blank=%b expected 0 1110 0", d, ssd_ctl, blank);
        end
        step(4);
        tests++;
        if (ssd_ctl !== 4'b1111 || blank !== 1'b1) begin
            errors++; $display("FAIL lz_zero_dig1: ssd_ctl=%b blank=%b expected 1111 1", ssd_ctl, blank);
        end
        blank_lz = 1'b0;
        step(4);
        tests++;
        if (ssd_ctl !== 4'b1011 || blank !== 1'b0) begin
            errors++; $display("FAIL nolz_dig2: ssd_ctl=%b blank=%b expected 1011 0", ssd_ctl, blank);
        end
        step(4);
        tests++;
        if (ssd_ctl !== 4'b0111 || blank !== 1'b0) begin
            errors++; $display("FAIL nolz_dig3: ssd_ctl=%b blank=%b expected 0111 0", ssd_ctl, blank);
        end
    endtask

    task automatic test_coincident();
        do_reset();
        load  = 1'b1;
        value = 16'hAAAA;
        step(1);
        load = 1'b0;
        step(14);
        tests++;
        if (pending !== 1'b1 || d !== 4'h0) begin
            errors++; $display("FAIL coin_pre: pending=%b d=%h expected 1 0", pending, d);
        end
        load  = 1'b1;
        value = 16'hBBBB;
        step(1);
        load = 1'b0;
        tests++;
        if (d !== 4'hA || ssd_ctl !== 4'b1110 || pending !== 1'b1) begin
            errors++;
            $display("FAIL coin_wrap: d=%h ssd_ctl=%b pending=%b expected a 1110 1", d, ssd_ctl, pending);
        end
        step(12);
        tests++;
        if (d !== 4'hA || ssd_ctl !== 4'b0111) begin
            errors++; $display("FAIL coin_dig3: d=%h ssd_ctl=%b expected a 0111", d, ssd_ctl);
        end
        step(4);
        tests++;
        if (d !== 4'hB || ssd_ctl !== 4'b1110 || pending !== 1'b0) begin
            errors++;
            $display("FAIL coin_next: d=%h ssd_ctl=%b pending=%b expected b 1110 0", d, ssd_ctl, pending);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        load  = 1'b1;
        value = 16'h1234;
        step(1);
        load = 1'b0;
        step(4);
        tests++;
        if (ssd_ctl !== 4'b1101 || pending !== 1'b1) begin
            errors++; $display("FAIL arst_pre: ssd_ctl=%b pending=%b expected 1101 1", ssd_ctl, pending);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (ssd_ctl !== 4'b1110 || d !== 4'h0 || pending !== 1'b0 || frame_done !== 1'b0 || blank !== 1'b0) begin
            errors++;
            $display("FAIL arst_now: ssd_ctl=%b d=%h pending=%b fd=%b blank=%b expected 1110 0 0 0 0",
                     ssd_ctl, d, pending, frame_done, blank);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(16);
        tests++;
        if (d !== 4'h0 || pending !== 1'b0 || ssd_ctl !== 4'b1110) begin
            errors++;
            $display("FAIL arst_discard: d=%h pending=%b ssd_ctl=%b expected 0 0 1110", d, pending, ssd_ctl);
        end
    endtask

    task automatic test_frame_done();
        int pulses;
        logic exp_fd;
        pulses = 0;
        do_reset();
        for (int n = 1; n <= 64; n++) begin
            step(1);
            exp_fd = ((n % 16) == 0);
            tests++;
            if (frame_done !== exp_fd) begin
                errors++; $display("FAIL fd_edge%0d: fd=%b expected %b", n, frame_done, exp_fd);
            end
            if (frame_done === 1'b1) begin
                pulses++;
                tests++;
                if (ssd_ctl !== 4'b1110) begin
                    errors++; $display("FAIL fd_align%0d: ssd_ctl=%b expected 1110", n, ssd_ctl);
                end
            end
        end
        tests++;
        if (pulses != 4) begin
            errors++; $display("FAIL fd_count: pulses=%0d expected 4", pulses);
        end
    endtask

    initial begin
        tests    = 0;
        errors   = 0;
        rst_n    = 1'b0;
        load     = 1'b0;
        value    = 16'h0000;
        blank_lz = 1'b0;
        test_reset();
        test_load();
        test_blank();
        test_coincident();
        test_async_reset();
        test_frame_done();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/ssd_scan_ctl.md
Name: ssd_scan_ctl

Overview:
- Time-multiplexing scan controller for the 4-digit seven-segment display.
- Takes a 16-bit packed value (four 4-bit nibbles) and cycles through the digits one at a time.
- For each digit it drives the active-low digit enable `ssd_ctl` and the current 4-bit digit code `d`.
- `d` feeds the existing combinational segment decoder downstream; this block replaces the static all-digits-on drive with a tear-free, refreshed scan.

Parameters:
- DIV_BITS, 17, prescaler width; one digit period = 2^DIV_BITS clocks (about 763 Hz per digit at 100 MHz). Benches use 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load  input  1  single-cycle strobe; capture `value` into the shadow register.
- value  input  16  packed digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- blank_lz  input  1  1 = blank leading zeros.
- d  output  4  nibble for the currently scanned digit, to the segment decoder.
- ssd_ctl  output  4  active-low one-hot digit enable; bit k drives digit k.
- blank  output  1  1 = current digit suppressed.
- frame_done  output  1  one-cycle pulse after digit 3's period ends.
- pending  output  1  a loaded value is waiting for the frame boundary.

Behaviour:
- Reset: one clock, `rst_n` asynchronous active-low.
  - Assertion immediately clears: prescaler cnt=0, idx=0, shadow=0, active=0.
  - Outputs at reset: pending=0, frame_done=0, ssd_ctl=4'b1110, d=4'h0, blank=0.
  - No clock edge is needed; this applies mid-frame too, and any pending load is discarded.
- Prescaler:
  - `cnt` increments every clock and wraps from 2^DIV_BITS-1 to 0.
  - tick = (cnt == all ones).
- Digit index: on a tick, idx <= idx+1 mod 4. Scan order is 0,1,2,3,0,…
- Frame wrap is defined as a tick with idx==3.
- Load/apply (double buffering):
  - load=1 gives shadow<=value and pending<=1.
  - On frame wrap: active<=shadow, pending<=0.
  - If load coincides with a frame wrap:
    - active takes the old shadow.
    - shadow takes the new value.
    - pending stays 1, so the new value is shown in the following frame.
  - `active` never changes except at a frame wrap, so no frame ever mixes digits of two values.
  - Multiple loads within one frame: the last one wins.
- Outputs are registered and update on the same edge as idx, computed from the next idx and next active. There is no extra latency.
  - d = active nibble[idx_next]. Values A–F pass through unchanged (hex).
  - ssd_ctl = ~(1<<idx_next), unless blanked, in which case it is 4'b1111.
  - blank = blanked flag.
- Leading-zero blanking:
  - Digit k (k=1..3) is blanked when blank_lz=1 and nibbles k..3 of active are all zero.
  - Digit 0 is never blanked.
  - blank_lz is sampled combinationally at each output update.
  - `d` still carries the nibble when blanked.
- frame_done: register set to 1 on the frame-wrap edge and cleared on the next edge. It is high for exactly one clock per 4·2^DIV_BITS clocks.
- Between ticks all outputs hold their values.

Decomposition:
- Shared package holds:
  - SSD_DIGITS=4.
  - SSD_OFF=4'b1111.
  - Digit-enable encoding function (idx to active-low one-hot).
- One natural sub-module: `ssd_prescaler` (counter plus tick, parameterised DIV_BITS), reusable by other scan/debounce blocks.
- The segment decoder stays outside this block.

Test Plan (DIV_BITS=2):
1. Reset and scan:
   - rst_n low gives ssd_ctl=1110, d=0, pending=0, frame_done=0.
   - After release, ssd_ctl steps to 1101, 1011, 0111, 1110 at 4-clock spacing.
2. Tear-free load:
   - load 16'h1234 mid-frame: pending=1 and d unchanged until the frame wrap.
   - Next frame: d=4,3,2,1 with ssd_ctl 1110, 1101, 1011, 0111; pending=0 after the wrap.
3. Leading-zero blanking:
   - blank_lz=1, active=16'h0070: digit0 d=0 shown, digit1 d=7 shown, digits 2 and 3 ssd_ctl=1111, blank=1.
   - active=16'h0000: only digit 0 is enabled.
   - blank_lz=0: all four digits are shown.
4. Coincident load:
   - shadow=16'hAAAA pending, load 16'hBBBB exactly on the wrap tick.
   - Next frame shows AAAA with pending=1; the frame after shows BBBB with pending=0.
5. Async reset mid-operation: assert rst_n between clock edges while pending=1; outputs and pending return to reset values before the next clk edge.
6. frame_done: over 64 clocks, exactly 4 single-cycle pulses, each on the edge where ssd_ctl returns to 1110.
